// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Time-multiplexed BCD 7-segment scanner with decimal points,
//            dead time, PWM brightness and frame-synchronous data update.
// Options  : LEADING_ZERO_SUPPRESS_EN - blank leading zero digits
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
   parameter int DIS_NUM   = 4,
   parameter int MLT_CNT   = 10,
   parameter int BLANK_CNT = 2,
   parameter int BW        = $clog2(MLT_CNT + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [DIS_NUM*4-1:0] i_bcd_data,
   input  logic [DIS_NUM-1:0]   i_dp,
   input  logic                 i_load,
   input  logic [BW-1:0]        i_bright,
   output logic [6:0]           o_seg,
   output logic                 o_dp,
   output logic [DIS_NUM-1:0]   o_bcd_sel,
   output logic                 o_frame_done
);

   localparam int c_SW = $clog2(MLT_CNT);
   localparam int c_DW = $clog2(DIS_NUM);
   localparam logic [c_SW-1:0]    c_SLOT_LAST  = c_SW'(MLT_CNT - 1);
   localparam logic [c_SW-1:0]    c_SLOT_BLANK = c_SW'(BLANK_CNT);
   localparam logic [c_DW-1:0]    c_DIG_LAST   = c_DW'(DIS_NUM - 1);
   localparam logic [BW-1:0]      c_BRIGHT_RST = BW'(MLT_CNT);
   localparam logic [DIS_NUM-1:0] c_SEL_ONE    = DIS_NUM'(1);

   logic [c_SW-1:0]      r_slot_cnt;
   logic [c_DW-1:0]      r_dig_idx;
   logic [DIS_NUM*4-1:0] r_stg_data;
   logic [DIS_NUM*4-1:0] r_act_data;
   logic [DIS_NUM-1:0]   r_stg_dp;
   logic [DIS_NUM-1:0]   r_act_dp;
   logic [BW-1:0]        r_stg_bright;
   logic [BW-1:0]        r_act_bright;
   logic                 r_load_pend;

   logic                 w_slot_last;
   logic                 w_frame_end;
   logic                 w_sel_on;
   logic [3:0]           w_nib [DIS_NUM];
   logic [DIS_NUM-1:0]   w_lz_blank;
   logic [3:0]           w_cur_nib;
   logic                 w_cur_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   assign w_slot_last = (r_slot_cnt == c_SLOT_LAST);
   assign w_frame_end = w_slot_last && (r_dig_idx == c_DIG_LAST);
   // An active brightness at or below the blank count leaves this window empty
   assign w_sel_on    = (r_slot_cnt >= c_SLOT_BLANK) && (BW'(r_slot_cnt) < r_act_bright);

   // Digit 0 sits in the most significant nibble
   for (genvar k = 0; k < DIS_NUM; k++) begin : g_nib
      assign w_nib[k] = r_act_data[(DIS_NUM-k)*4-1 -: 4];
   end

`ifdef LEADING_ZERO_SUPPRESS_EN
   // Digit k is blank when it and every more-significant digit is zero
   for (genvar k = 0; k < DIS_NUM; k++) begin : g_lzs
      if (k == DIS_NUM - 1) begin : g_last
         assign w_lz_blank[k] = 1'b0;
      end else if (k == 0) begin : g_first
         assign w_lz_blank[k] = (w_nib[k] == 4'd0);
      end else begin : g_mid
         assign w_lz_blank[k] = (w_nib[k] == 4'd0) && w_lz_blank[k-1];
      end
   end
`else
   assign w_lz_blank = '0;
`endif

   assign w_cur_nib   = w_nib[r_dig_idx];
   assign w_cur_blank = w_lz_blank[r_dig_idx];

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_slot_cnt   <= '0;
         r_dig_idx    <= '0;
         r_stg_data   <= '0;
         r_act_data   <= '0;
         r_stg_dp     <= '0;
         r_act_dp     <= '0;
         r_stg_bright <= '0;
         r_act_bright <= c_BRIGHT_RST;
         r_load_pend  <= 1'b0;
         o_seg        <= '0;
         o_dp         <= 1'b0;
         o_bcd_sel    <= '0;
         o_frame_done <= 1'b0;
      end else begin
         r_slot_cnt <= w_slot_last ? '0 : r_slot_cnt + 1'b1;
         if (w_slot_last) begin
            r_dig_idx <= (r_dig_idx == c_DIG_LAST) ? '0 : r_dig_idx + 1'b1;
         end

         if (i_load) begin
            r_stg_data   <= i_bcd_data;
            r_stg_dp     <= i_dp;
            r_stg_bright <= i_bright;
         end
         // A load on the boundary edge stays pending for the following frame
         if (w_frame_end && r_load_pend) begin
            r_act_data   <= r_stg_data;
            r_act_dp     <= r_stg_dp;
            r_act_bright <= r_stg_bright;
            r_load_pend  <= i_load;
         end else if (i_load) begin
            r_load_pend  <= 1'b1;
         end

         o_frame_done <= w_frame_end;
         if (w_sel_on) begin
            o_bcd_sel <= c_SEL_ONE << r_dig_idx;
            o_seg     <= w_cur_blank ? 7'h00 : seg_decode(w_cur_nib);
            o_dp      <= r_act_dp[r_dig_idx];
         end else begin
            o_bcd_sel <= '0;
            o_seg     <= '0;
            o_dp      <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
